// File: rtl/gps_ca_tx_if.sv
// gps_ca_tx_if: navigation-bit valid/ready handshake into the C/A generator.
interface gps_ca_tx_if;
  logic bit_data;
  logic bit_valid;
  logic bit_ready;
  modport master(output bit_data, bit_valid, input bit_ready);
  modport slave(input bit_data, bit_valid, output bit_ready);
endinterface

// File: rtl/gps_ca_tx.sv
// gps_ca_tx: GPS L1 C/A Gold-code BPSK baseband generator with NCO chip timing.
// Define GPS_TX_CARRIER_EN to add a square-wave carrier IF (carr_fcw input).
module gps_ca_tx #(
  parameter int ACC_W = 32,
  parameter int G2_TAP_A = 2,
  parameter int G2_TAP_B = 6,
  parameter int CODES_PER_BIT = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic [ACC_W-1:0] chip_fcw,
`ifdef GPS_TX_CARRIER_EN
  input  logic [ACC_W-1:0] carr_fcw,
`endif
  gps_ca_tx_if.slave bit_if,
  output logic tx_out,
  output logic chip_strobe,
  output logic [9:0] chip_index,
  output logic epoch,
  output logic bit_epoch,
  output logic underrun
);
  localparam int CW = $clog2(CODES_PER_BIT + 1);
  localparam logic [CW-1:0] LAST_CODE = CW'(CODES_PER_BIT - 1);
  typedef enum logic [1:0] {IDLE, WAIT_BIT, RUN} state_t;
  state_t state, state_n;
  logic [ACC_W-1:0] acc, acc_n;
  logic carry;
  logic [9:0] g1, g2, g1_n, g2_n, idx_n;
  logic [CW-1:0] cnt, cnt_n;
  logic cur_bit, cur_n, next_bit, nb_n, next_full, nf_n;
  logic und_n, strobe_n, epoch_n, bep_n, tx_n, carr_msb_n;
  function automatic logic chip(input logic [9:0] a, input logic [9:0] b);
    return a[9] ^ b[G2_TAP_A-1] ^ b[G2_TAP_B-1];
  endfunction
  assign bit_if.bit_ready = (state == WAIT_BIT) || (state == RUN && !next_full);
`ifdef GPS_TX_CARRIER_EN
  logic [ACC_W-1:0] carr, carr_n;
  assign carr_n = (en && state == RUN) ? carr + carr_fcw : '0;
  assign carr_msb_n = carr_n[ACC_W-1];
  always_ff @(posedge clk or posedge rst)
    if (rst) carr <= '0;
    else carr <= carr_n;
`else
  assign carr_msb_n = 1'b0;
`endif
  always_comb begin
    state_n = state;
    acc_n = acc;
    g1_n = g1;
    g2_n = g2;
    idx_n = chip_index;
    cnt_n = cnt;
    cur_n = cur_bit;
    nb_n = next_bit;
    nf_n = next_full;
    und_n = underrun;
    strobe_n = 1'b0;
    epoch_n = 1'b0;
    bep_n = 1'b0;
    carry = 1'b0;
    case (state)
      IDLE: state_n = WAIT_BIT;
      WAIT_BIT:
        if (bit_if.bit_valid) begin
          cur_n = bit_if.bit_data;
          state_n = RUN;
        end
      RUN: begin
        {carry, acc_n} = {1'b0, acc} + {1'b0, chip_fcw};
        if (bit_if.bit_valid && !next_full) begin
          nb_n = bit_if.bit_data;
          nf_n = 1'b1;
        end
        if (carry) begin
          strobe_n = 1'b1;
          // Reload at wrap keeps the LFSRs aligned to chip 0 even if a fault ever desyncs them.
          if (chip_index == 10'd1022) begin
            idx_n = '0;
            g1_n = '1;
            g2_n = '1;
            epoch_n = 1'b1;
            cnt_n = (cnt == LAST_CODE) ? '0 : cnt + 1'b1;
            if (cnt == LAST_CODE) begin
              bep_n = 1'b1;
              cur_n = next_full & next_bit;
              und_n = underrun | !next_full;
              if (next_full) nf_n = 1'b0;
            end
          end else begin
            idx_n = chip_index + 10'd1;
            g1_n = {g1[8:0], g1[2] ^ g1[9]};
            g2_n = {g2[8:0], g2[1] ^ g2[2] ^ g2[5] ^ g2[7] ^ g2[8] ^ g2[9]};
          end
        end
      end
      default: state_n = IDLE;
    endcase
    if (!en) begin
      state_n = IDLE;
      acc_n = '0;
      g1_n = '1;
      g2_n = '1;
      idx_n = '0;
      cnt_n = '0;
      cur_n = 1'b0;
      nb_n = 1'b0;
      nf_n = 1'b0;
      und_n = 1'b0;
      strobe_n = 1'b0;
      epoch_n = 1'b0;
      bep_n = 1'b0;
    end
    // Output register is loaded from next-state values so it lines up with chip_index.
    tx_n = (state_n == RUN) && (chip(g1_n, g2_n) ^ cur_n ^ carr_msb_n);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      acc <= '0;
      g1 <= '1;
      g2 <= '1;
      chip_index <= '0;
      cnt <= '0;
      cur_bit <= 1'b0;
      next_bit <= 1'b0;
      next_full <= 1'b0;
      underrun <= 1'b0;
      chip_strobe <= 1'b0;
      epoch <= 1'b0;
      bit_epoch <= 1'b0;
      tx_out <= 1'b0;
    end else begin
      state <= state_n;
      acc <= acc_n;
      g1 <= g1_n;
      g2 <= g2_n;
      chip_index <= idx_n;
      cnt <= cnt_n;
      cur_bit <= cur_n;
      next_bit <= nb_n;
      next_full <= nf_n;
      underrun <= und_n;
      chip_strobe <= strobe_n;
      epoch <= epoch_n;
      bit_epoch <= bep_n;
      tx_out <= tx_n;
    end
endmodule

// File: tb/tb_gps_ca_tx.sv
// tb_gps_ca_tx: directed checks of PRN1 chips, epochs, bit handshake, underrun, en drop and async reset.
module tb_gps_ca_tx;
  localparam logic [9:0] PRN1 = 10'b1100100000;
`ifdef GPS_TX_CARRIER_EN
  localparam bit CARRIER = 1'b1;
`else
  localparam bit CARRIER = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, en = 1'b0;
  logic [31:0] chip_fcw = 32'h8000_0000;
  logic tx_out, chip_strobe, epoch, bit_epoch, underrun;
  logic [9:0] chip_index;
  int n_cmp = 0, n_bad = 0;
  gps_ca_tx_if bif();
  gps_ca_tx dut (
    .clk(clk), .rst(rst), .en(en), .chip_fcw(chip_fcw),
`ifdef GPS_TX_CARRIER_EN
    .carr_fcw(32'h4000_0000),
`endif
    .bit_if(bif), .tx_out(tx_out), .chip_strobe(chip_strobe), .chip_index(chip_index),
    .epoch(epoch), .bit_epoch(bit_epoch), .underrun(underrun)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic logic prn_bit(input int i);
    logic [9:0] p;
    p = PRN1;
    return p[9-i];
  endfunction
  function automatic logic car(input int c);
    return CARRIER & c[1];
  endfunction
  task automatic send(input logic b);
    bit ok;
    ok = 1'b0;
    bif.bit_data = b;
    bif.bit_valid = 1'b1;
    for (int i = 0; i < 8 && !ok; i++) begin
      ok = bif.bit_ready;
      tick();
    end
    check("accept", ok, 1);
  endtask
  task automatic run(input logic b0, input logic two, input int last);
    int ne, nb;
    ne = 0;
    nb = 0;
    en = 1'b0;
    tick();
    en = 1'b1;
    send(b0);
    if (two) bif.bit_data = 1'b0;
    else bif.bit_valid = 1'b0;
    for (int c = 0; c <= last; c++) begin
      if (c == 1) bif.bit_valid = 1'b0;
      if (c > 0 && c <= 2046) ne += int'(epoch);
      if (c > 0) nb += int'(bit_epoch);
      if (c % 2 == 0 && (c < 20 || (c >= 2046 && c < 2066) || (c >= 40920 && c < 40940)))
        check("tx_chip", tx_out, prn_bit((c % 2046) / 2) ^ (c >= 40920 ? 1'b0 : b0) ^ car(c));
      if (c == 2045) check("idx_1022", chip_index, 1022);
      if (c == 2046) begin
        check("epoch_pulse", epoch, 1);
        check("idx_wrap", chip_index, 0);
        check("epoch_count", ne, 1);
      end
      if (c == 40919) begin
        check("bit_epoch_early", nb, 0);
        check("underrun_early", underrun, 0);
      end
      if (c == 40920) begin
        check("bit_epoch", bit_epoch, 1);
        check("underrun_at_bit", underrun, !two);
      end
      if (two && (c == 1 || c == 40919)) check("ready_full", bif.bit_ready, 0);
      if (two && c == 40920) check("ready_free", bif.bit_ready, 1);
      if (!two && c == last) check("underrun_sticky", underrun, 1);
      tick();
    end
  endtask
  initial begin
    bif.bit_data = 1'b0;
    bif.bit_valid = 1'b0;
    tick();
    check("rst_tx", tx_out, 0);
    check("rst_ready", bif.bit_ready, 0);
    check("rst_idx", chip_index, 0);
    check("rst_underrun", underrun, 0);
    check("rst_pulses", {chip_strobe, epoch, bit_epoch}, 0);
    rst = 1'b0;
    tick();
    run(1'b1, 1'b1, 40940);
    run(1'b1, 1'b0, 40940);
    for (int i = 0; i < 2100 && chip_index != 10'd500; i++) tick();
    check("reach_500", chip_index, 500);
    check("underrun_hold", underrun, 1);
    en = 1'b0;
    tick();
    check("endrop_idx", chip_index, 0);
    check("endrop_tx", tx_out, 0);
    check("endrop_underrun", underrun, 0);
    check("endrop_ready", bif.bit_ready, 0);
    en = 1'b1;
    send(1'b0);
    bif.bit_valid = 1'b0;
    for (int c = 0; c < 20; c++) begin
      check("strobe", chip_strobe, c > 0 && c % 2 == 0);
      if (c % 2 == 0) check("tx_prn1", tx_out, prn_bit(c / 2) ^ car(c));
      tick();
    end
    repeat (81) tick();
    check("pre_rst_idx", chip_index, 50);
    #2 rst = 1'b1;
    #1;
    check("arst_idx", chip_index, 0);
    check("arst_tx", tx_out, 0);
    check("arst_ready", bif.bit_ready, 0);
    check("arst_strobe", chip_strobe, 0);
    rst = 1'b0;
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
